// File: rtl/draw_pkg.sv
// Shared definitions for the draw unit, its CPU-side control logic and the
// rectangle span generator: screen geometry, command-word layout, FSM states.
package draw_pkg;

  // Screen geometry and field widths
  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;
  localparam int unsigned COLOR_W  = 3;
  localparam int unsigned X_W      = 8;
  localparam int unsigned Y_W      = 7;
  localparam int unsigned WORD_W   = 16;

  // Single-word full-screen clear command
  localparam logic [WORD_W-1:0] CLEAR_WORD = 16'hFFFF;

  // Word A (row header): {6'b0, color, y}
  localparam int unsigned WA_Y_LSB     = 0;
  localparam int unsigned WA_COLOR_LSB = 7;
  // Word B (span): {xs, xe}
  localparam int unsigned WB_XE_LSB    = 0;
  localparam int unsigned WB_XS_LSB    = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WA   = 3'd1,
    ST_WB   = 3'd2,
    ST_CLR  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  // Build a row-header word
  function automatic logic [WORD_W-1:0] make_word_a(input logic [COLOR_W-1:0] c,
                                                    input logic [Y_W-1:0]     y);
    logic [WORD_W-1:0] w;
    w = '0;
    w[WA_COLOR_LSB +: COLOR_W] = c;
    w[WA_Y_LSB +: Y_W]         = y;
    return w;
  endfunction

  // Build a span word
  function automatic logic [WORD_W-1:0] make_word_b(input logic [X_W-1:0] xs,
                                                    input logic [X_W-1:0] xe);
    logic [WORD_W-1:0] w;
    w = '0;
    w[WB_XS_LSB +: X_W] = xs;
    w[WB_XE_LSB +: X_W] = xe;
    return w;
  endfunction

endpackage

// File: rtl/rect_span_gen.sv
// Expands one filled-rectangle or clear request into draw-unit span commands,
// one {header, span} word pair per row, honouring FIFO back-pressure.
// Ports:
//   clk, reset          clock, async active-low reset
//   start, clear        one-cycle requests, sampled only when idle
//   x0, x1, y0, y1      rectangle bounds (any order, clamped to screen)
//   color               fill colour
//   full                draw-unit FIFO full
//   we, dataOut         write strobe and command word to the draw unit
//   busy, done          not-idle flag, end-of-request pulse
module rect_span_gen
  import draw_pkg::*;
#(
  parameter int unsigned XMAX = SCREEN_W - 1,
  parameter int unsigned YMAX = SCREEN_H - 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                clear,
  input  logic [X_W-1:0]      x0,
  input  logic [X_W-1:0]      x1,
  input  logic [Y_W-1:0]      y0,
  input  logic [Y_W-1:0]      y1,
  input  logic [COLOR_W-1:0]  color,
  input  logic                full,
  output logic                we,
  output logic [WORD_W-1:0]   dataOut,
  output logic                busy,
  output logic                done
);

  localparam logic [X_W-1:0] X_LIM = X_W'(XMAX);
  localparam logic [Y_W-1:0] Y_LIM = Y_W'(YMAX);

  // Order a column pair and clamp both ends; returns {lo, hi}
  function automatic logic [2*X_W-1:0] order_clamp_x(input logic [X_W-1:0] a,
                                                     input logic [X_W-1:0] b);
    logic [X_W-1:0] lo;
    logic [X_W-1:0] hi;
    lo = (a < b) ? a : b;
    hi = (a < b) ? b : a;
    if (lo > X_LIM) lo = X_LIM;
    if (hi > X_LIM) hi = X_LIM;
    return {lo, hi};
  endfunction

  // Order a row pair and clamp both ends; returns {lo, hi}
  function automatic logic [2*Y_W-1:0] order_clamp_y(input logic [Y_W-1:0] a,
                                                     input logic [Y_W-1:0] b);
    logic [Y_W-1:0] lo;
    logic [Y_W-1:0] hi;
    lo = (a < b) ? a : b;
    hi = (a < b) ? b : a;
    if (lo > Y_LIM) lo = Y_LIM;
    if (hi > Y_LIM) hi = Y_LIM;
    return {lo, hi};
  endfunction

  state_e               r_state;
  state_e               w_state_nxt;

  logic [X_W-1:0]       r_xs;
  logic [X_W-1:0]       r_xe;
  logic [Y_W-1:0]       r_y;
  logic [Y_W-1:0]       r_ye;
  logic [COLOR_W-1:0]   r_color;
  logic [X_W-1:0]       w_xs_nxt;
  logic [X_W-1:0]       w_xe_nxt;
  logic [Y_W-1:0]       w_y_nxt;
  logic [Y_W-1:0]       w_ye_nxt;
  logic [COLOR_W-1:0]   w_color_nxt;

  logic [2*X_W-1:0]     w_xb;
  logic [2*Y_W-1:0]     w_yb;

  logic                 r_active;
  logic [WORD_W-1:0]    r_dout;
  logic                 r_busy;
  logic                 r_done;
  logic                 w_active_nxt;
  logic [WORD_W-1:0]    w_dout_nxt;
  logic                 w_busy_nxt;
  logic                 w_done_nxt;

  // State, operand and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_xs     <= '0;
      r_xe     <= '0;
      r_y      <= '0;
      r_ye     <= '0;
      r_color  <= '0;
      r_active <= 1'b0;
      r_dout   <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_xs     <= w_xs_nxt;
      r_xe     <= w_xe_nxt;
      r_y      <= w_y_nxt;
      r_ye     <= w_ye_nxt;
      r_color  <= w_color_nxt;
      r_active <= w_active_nxt;
      r_dout   <= w_dout_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
    end
  end

  // Next-state, operand latch and registered-output decode
  always_comb begin
    w_state_nxt = r_state;
    w_xs_nxt    = r_xs;
    w_xe_nxt    = r_xe;
    w_y_nxt     = r_y;
    w_ye_nxt    = r_ye;
    w_color_nxt = r_color;
    w_xb        = order_clamp_x(x0, x1);
    w_yb        = order_clamp_y(y0, y1);

    case (r_state)
      ST_IDLE: begin
        // clear has priority over start
        if (clear) begin
          w_state_nxt = ST_CLR;
        end else if (start) begin
          w_state_nxt = ST_WA;
          w_xs_nxt    = w_xb[2*X_W-1:X_W];
          w_xe_nxt    = w_xb[X_W-1:0];
          w_y_nxt     = w_yb[2*Y_W-1:Y_W];
          w_ye_nxt    = w_yb[Y_W-1:0];
          w_color_nxt = color;
        end
      end
      ST_WA: begin
        if (!full) w_state_nxt = ST_WB;
      end
      ST_WB: begin
        if (!full) begin
          if (r_y == r_ye) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_WA;
            // y is clamped to YMAX, so this cannot wrap
            w_y_nxt     = Y_W'(r_y + Y_W'(1));
          end
        end
      end
      ST_CLR: begin
        if (!full) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    // Outputs are decoded from the next state so they are registered and
    // already valid in the first cycle of each state.
    w_active_nxt = (w_state_nxt == ST_WA) || (w_state_nxt == ST_WB) ||
                   (w_state_nxt == ST_CLR);
    w_busy_nxt   = (w_state_nxt != ST_IDLE);
    w_done_nxt   = (w_state_nxt == ST_DONE);
    case (w_state_nxt)
      ST_WA:   w_dout_nxt = make_word_a(w_color_nxt, w_y_nxt);
      ST_WB:   w_dout_nxt = make_word_b(w_xs_nxt, w_xe_nxt);
      ST_CLR:  w_dout_nxt = CLEAR_WORD;
      default: w_dout_nxt = '0;
    endcase
  end

  // Write strobe reacts to full within the same cycle
  assign we      = r_active & ~full;
  assign dataOut = r_dout;
  assign busy    = r_busy;
  assign done    = r_done;

endmodule

// File: tb/tb_rect_span_gen.sv
// Directed bench for rect_span_gen: records every written word and done pulse
// with its edge index and compares against hand-computed sequences.
module tb_rect_span_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        clear;
  logic [7:0]  x0;
  logic [7:0]  x1;
  logic [6:0]  y0;
  logic [6:0]  y1;
  logic [2:0]  color;
  logic        full;
  logic        we;
  logic [15:0] dataOut;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [15:0] wq[$];
  int          wcyc[$];
  int          done_cyc[$];

  rect_span_gen dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .clear   (clear),
    .x0      (x0),
    .x1      (x1),
    .y0      (y0),
    .y1      (y1),
    .color   (color),
    .full    (full),
    .we      (we),
    .dataOut (dataOut),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  // Edge counter and write/done recorder (reads pre-edge values)
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (we) begin
      wq.push_back(dataOut);
      wcyc.push_back(cyc);
    end
    if (done) done_cyc.push_back(cyc);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue a request; c returns the edge index at which it is sampled
  task automatic kick(input logic [7:0] a, input logic [7:0] b,
                      input logic [6:0] ya, input logic [6:0] yb,
                      input logic [2:0] col, input logic clr, output int c);
    wq.delete();
    wcyc.delete();
    done_cyc.delete();
    x0 = a; x1 = b; y0 = ya; y1 = yb; color = col;
    start = 1'b1;
    clear = clr;
    c = cyc;
    tick();
    start = 1'b0;
    clear = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    chk({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic check_run(input string tag, input logic [15:0] exp[$],
                           input int c, input int extra);
    chk({tag, "_nwords"}, 32'(wq.size()), 32'(exp.size()));
    foreach (exp[i])
      chk($sformatf("%s_w%0d", tag, i),
          (i < wq.size()) ? {16'h0, wq[i]} : 32'hFFFF_FFFF, {16'h0, exp[i]});
    chk({tag, "_t_first"}, (wcyc.size() > 0) ? 32'(wcyc[0]) : 32'hFFFF_FFFF, 32'(c + 1));
    chk({tag, "_ndone"}, 32'(done_cyc.size()), 32'd1);
    chk({tag, "_t_done"}, (done_cyc.size() > 0) ? 32'(done_cyc[0]) : 32'hFFFF_FFFF,
        32'(c + exp.size() + 1 + extra));
  endtask

  initial begin
    int c;
    logic [15:0] e[$];

    reset = 1'b0; start = 1'b0; clear = 1'b0; full = 1'b0;
    x0 = '0; x1 = '0; y0 = '0; y1 = '0; color = '0;
    #1;
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_dout", 32'(dataOut), 32'd0);
    tick();
    tick();
    reset = 1'b1;
    tick();

    // Single row
    kick(8'd10, 8'd20, 7'd5, 7'd5, 3'd3, 1'b0, c);
    chk("single_busy", 32'(busy), 32'd1);
    chk("single_dout0", 32'(dataOut), 32'h0185);
    wait_idle("single");
    e = '{16'h0185, 16'h0A14};
    check_run("single", e, c, 0);

    // Swapped bounds; a start pulse with new operands while busy is ignored
    kick(8'd20, 8'd10, 7'd3, 7'd1, 3'd7, 1'b0, c);
    x0 = 8'd99; y1 = 7'd50; start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle("swap");
    tick(); tick();
    e = '{16'h0381, 16'h0A14, 16'h0382, 16'h0A14, 16'h0383, 16'h0A14};
    check_run("swap", e, c, 0);

    // Back-pressure: full high for 5 cycles after the first word B
    kick(8'd1, 8'd2, 7'd10, 7'd12, 3'd2, 1'b0, c);
    tick();
    tick();
    full = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("stall_we%0d", k), 32'(we), 32'd0);
      chk($sformatf("stall_dout%0d", k), 32'(dataOut), 32'h010B);
      tick();
    end
    full = 1'b0;
    wait_idle("stall");
    e = '{16'h010A, 16'h0102, 16'h010B, 16'h0102, 16'h010C, 16'h0102};
    check_run("stall", e, c, 5);

    // Clamp
    kick(8'd0, 8'd200, 7'd127, 7'd127, 3'd1, 1'b0, c);
    wait_idle("clamp");
    e = '{16'h00F7, 16'h009F};
    check_run("clamp", e, c, 0);

    // Clear wins over start; start during CLR/DONE ignored
    kick(8'd5, 8'd6, 7'd7, 7'd8, 3'd4, 1'b1, c);
    chk("clr_dout", 32'(dataOut), 32'hFFFF);
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    wait_idle("clr");
    tick(); tick(); tick();
    e = '{16'hFFFF};
    check_run("clr", e, c, 0);

    // Reset during the second row
    kick(8'd30, 8'd40, 7'd2, 7'd4, 3'd5, 1'b0, c);
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("mid_we", 32'(we), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_dout", 32'(dataOut), 32'd0);
    chk("mid_done", 32'(done), 32'd0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("mid_nwords", 32'(wq.size()), 32'd2);
    chk("mid_ndone", 32'(done_cyc.size()), 32'd0);

    kick(8'd30, 8'd40, 7'd2, 7'd4, 3'd5, 1'b0, c);
    wait_idle("post");
    e = '{16'h0282, 16'h1E28, 16'h0283, 16'h1E28, 16'h0284, 16'h1E28};
    check_run("post", e, c, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rect_span_gen.md
# rect_span_gen

Upstream command generator for the draw unit's line-command FIFO. Accepts one filled-rectangle (or full-screen clear) request from the CPU-side control logic and expands it into the two-word horizontal-span commands the draw unit consumes: one command pair per row, 160x120 screen, 3-bit colour. It honours the draw unit's `full` back-pressure, so no command word is ever dropped or duplicated.

## Interface
Parameters:
- `XMAX`, 159: last valid column.
- `YMAX`, 119: last valid row.

Ports:
- `clk`  in  1  system clock (same clock as the draw unit's `clk`).
- `reset`  in  1  asynchronous, active-low reset (0 = reset).
- `start`  in  1  one-cycle request to draw a rectangle; sampled only in IDLE.
- `clear`  in  1  one-cycle request to emit the clear command; sampled only in IDLE.
- `x0`, `x1`  in  8  rectangle column bounds, any order.
- `y0`, `y1`  in  7  rectangle row bounds, any order.
- `color`  in  3  fill colour.
- `full`  in  1  draw-unit FIFO full.
- `we`  out  1  write strobe to draw unit `we`.
- `dataOut`  out  16  command word to draw unit `dataIn`.
- `busy`  out  1  high in any state except IDLE.
- `done`  out  1  one-cycle pulse after the final word of a request is written.

## Operation
- Word A (row header): {6'b0, color[2:0], y[6:0]}. Word B (span): {xs[7:0], xe[7:0]}. Clear command: 16'hFFFF, single word.
- On `start` in IDLE, latch the inputs. Order the bounds: xs=min(x0,x1), xe=max(x0,x1), ys=min(y0,y1), ye=max(y0,y1). Clamp after ordering: any value >XMAX becomes XMAX, any value >YMAX becomes YMAX. Load row counter y=ys.
- States:
  - IDLE: `clear` goes to CLR. Otherwise `start` goes to WA. `clear` wins when both are high.
  - WA: `dataOut`=word A. On write, go to WB.
  - WB: `dataOut`=word B. On write, go to DONE if y==ye; otherwise y<=y+1 and go to WA.
  - CLR: `dataOut`=16'hFFFF. On write, go to DONE.
  - DONE: `done`=1 for one cycle, then go to IDLE.
- Write rule: `we` = (state in {WA, WB, CLR}) & ~`full`. This is combinational on `full`. A word counts as written exactly in the cycle `we`=1 at a rising `clk` edge.
- While `full`=1: `we`=0 and the state and `dataOut` hold stable.
- `start`/`clear` while busy: ignored, no queuing.
- Latched operands are immune to input changes after the `start` cycle.
- y increment is 7-bit. Because y is clamped to ≤YMAX, it cannot wrap. A rectangle with ys==ye emits exactly one pair.

## Timing
- Reset values (asynchronous, immediate on `reset`=0): state IDLE, `we`=0, `dataOut`=0, `busy`=0, `done`=0, y=0.
- Reset mid-operation aborts the request. No further words are emitted. `done` is not pulsed.
- Latency: `start` at edge n means WA is active after edge n. The first `we` can be high in cycle n+1.
- With `full`=0 throughout, an R-row rectangle writes 2R words in cycles n+1 … n+2R. `done` is high in cycle n+2R+1, and the block is back in IDLE at cycle n+2R+2.
- Clear: word written in cycle n+1, `done` in cycle n+2.
- Each cycle of `full`=1 while in WA/WB/CLR adds exactly one cycle of latency.
- `dataOut` is a registered/state-decoded value. It is glitch-free and stable for the whole write cycle.

## Structure
- Shared package `draw_pkg` holds:
  - `SCREEN_W`=160, `SCREEN_H`=120, `COLOR_W`=3, `CLEAR_WORD`=16'hFFFF.
  - Word-field bit positions.
  - The state enum {IDLE, WA, WB, CLR, DONE}.
- The draw unit and the CPU-side control logic use the same package.
- Single module with no sub-module. The bound order/clamp logic is a local function, not a separate block.

## Test plan
- Single row: x0=10, x1=20, y0=y1=5, color=3, `full`=0.
  - Words 16'h0185 then 16'h0A14 in consecutive cycles.
  - `done` one cycle later, `busy` then low.
- Swapped bounds: x0=20, x1=10, y0=3, y1=1, color=7.
  - Emits 0x0381/0x0A14, 0x0382/0x0A14, 0x0383/0x0A14.
  - Exactly 6 `we` pulses.
- Back-pressure: 3-row rectangle with `full` held high for 5 cycles after the first word B.
  - `we`=0 and `dataOut` stable during the stall.
  - Total of 6 words, none duplicated or lost.
  - `done` is 5 cycles later than in the unstalled run.
- Clamp: x0=0, x1=200, y0=y1=127, color=1.
  - Words 16'h00F7 then 16'h009F. Single pair only.
- Clear: `clear`=1 together with `start`=1 in IDLE.
  - Exactly one word 16'hFFFF, then `done`. The rectangle is not drawn.
  - A `start` pulsed while busy is ignored.
- Reset mid-operation: assert `reset`=0 during the second row.
  - `we`/`busy`/`dataOut` drop to 0 immediately with no `done`.
  - After release, a new `start` produces a correct sequence from row ys.
